addr_pass_ctrl: RTL and testbench

- Sequences one complete read pass over a 2^AW-entry dual-address memory. Drives the B address as a linear index and the A address under a configurable rewind/wrap rule.
- Sits between the host or control FSM (start/done handshake) and the memory read port (rd_en, addr_a, addr_b). The downstream consumer can stall it.
- Replaces free-running address counters with a start/stop, stall-aware, reconfigurable scheduler.

---
 rtl/addr_pass_ctrl_pkg.sv | 15 +
 rtl/addr_pass_ctrl_if.sv | 30 +++
 rtl/addr_pass_ctrl_addr_a_step.sv | 24 ++
 rtl/addr_pass_ctrl.sv | 118 +++++++++++
 tb/tb_addr_pass_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/addr_pass_ctrl_pkg.sv
// Shared types and defaults for the dual-address read pass controller.
package addr_pass_ctrl_pkg;

    localparam int unsigned AW_DEF     = 4;
    localparam int unsigned LAST_B_DEF = 8;
    localparam int unsigned REWIND_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/addr_pass_ctrl_if.sv
// Host/memory-side signal bundle of the read pass controller.
interface addr_pass_ctrl_if
    import addr_pass_ctrl_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) ();

    logic          start;
    logic          stall;
    logic [AW-1:0] cfg_skip_a;
    logic [AW-1:0] cfg_skip_b;
    logic [AW-1:0] cfg_wrap;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic          last;
    logic          done;

    modport master (
        output start, stall, cfg_skip_a, cfg_skip_b, cfg_wrap,
        input  busy, rd_en, addr_a, addr_b, last, done
    );

    modport slave (
        input  start, stall, cfg_skip_a, cfg_skip_b, cfg_wrap,
        output busy, rd_en, addr_a, addr_b, last, done
    );

endinterface

// File: rtl/addr_pass_ctrl_addr_a_step.sv
// Next A address: rewind at either skip point, else wrap to 0, else increment.
module addr_a_step #(
    parameter int unsigned AW     = 4,
    parameter int unsigned REWIND = 2
) (
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [AW-1:0] skip_a,
    input  logic [AW-1:0] skip_b,
    input  logic [AW-1:0] wrap,
    output logic [AW-1:0] next_a
);

    // Both skips matching still rewind only once.
    always_comb begin
        next_a = addr_a + AW'(1);
        if ((addr_b == skip_a) || (addr_b == skip_b)) begin
            next_a = addr_a - AW'(REWIND);
        end else if (addr_a == wrap) begin
            next_a = '0;
        end
    end

endmodule

// File: rtl/addr_pass_ctrl.sv
// Start/stop, stall-aware scheduler issuing one full read pass of linear B and rewinding A.
module addr_pass_ctrl
    import addr_pass_ctrl_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned LAST_B = LAST_B_DEF,
    parameter int unsigned REWIND = REWIND_DEF
) (
    input  logic           clk,
    input  logic           reset,
    addr_pass_ctrl_if.slave bus
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [AW-1:0] skip_a_q, skip_a_d;
    logic [AW-1:0] skip_b_q, skip_b_d;
    logic [AW-1:0] wrap_q, wrap_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_en_c;
    logic          last_c;
    logic [AW-1:0] next_a_c;

    addr_a_step #(
        .AW     (AW),
        .REWIND (REWIND)
    ) u_addr_a_step (
        .addr_a (addr_a_q),
        .addr_b (addr_b_q),
        .skip_a (skip_a_q),
        .skip_b (skip_b_q),
        .wrap   (wrap_q),
        .next_a (next_a_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            skip_a_q <= '0;
            skip_b_q <= '0;
            wrap_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            skip_a_q <= skip_a_d;
            skip_b_q <= skip_b_d;
            wrap_q   <= wrap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state, next register values and the two combinational strobes.
    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        skip_a_d = skip_a_q;
        skip_b_d = skip_b_q;
        wrap_d   = wrap_q;
        rd_en_c  = 1'b0;
        last_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    skip_a_d = bus.cfg_skip_a;
                    skip_b_d = bus.cfg_skip_b;
                    wrap_d   = bus.cfg_wrap;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                addr_a_d = '0;
                addr_b_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (!bus.stall) begin
                    rd_en_c = 1'b1;
                    // Final read leaves the addresses parked on the last pair.
                    if (addr_b_q == AW'(LAST_B)) begin
                        last_c  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_b_d = addr_b_q + AW'(1);
                        addr_a_d = next_a_c;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.addr_a = addr_a_q;
    assign bus.addr_b = addr_b_q;
    assign bus.rd_en  = rd_en_c;
    assign bus.last   = last_c;

endmodule

// File: tb/tb_addr_pass_ctrl.sv
// Randomized bench for addr_pass_ctrl against a read-list reference model.
module tb_addr_pass_ctrl;

    localparam int unsigned AW     = 4;
    localparam int unsigned LAST_B = 8;
    localparam int unsigned REWIND = 2;
    localparam int          MODV   = 16;
    localparam int          NREADS = LAST_B + 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    addr_pass_ctrl_if #(.AW(AW)) bus ();

    addr_pass_ctrl #(
        .AW     (AW),
        .LAST_B (LAST_B),
        .REWIND (REWIND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected (a,b) read list of one pass, straight from the addressing rules.
    task automatic build_reads(input int sa, input int sb, input int wr,
                               output int ea[$], output int eb[$]);
        int a;
        a = 0;
        ea = {};
        eb = {};
        for (int b = 0; b < NREADS; b++) begin
            ea.push_back(a);
            eb.push_back(b);
            if (b == sa || b == sb)  a = (a + MODV - int'(REWIND)) % MODV;
            else if (a == wr)        a = 0;
            else                     a = (a + 1) % MODV;
        end
    endtask

    task automatic run_pass(input int sa, input int sb, input int wr,
                            input int stall_pct, input int st_idx, input int st_len,
                            input int abort_idx, input bit start_in_run,
                            input bit start_on_done, input int idle_gap);
        int ea[$];
        int eb[$];
        int idx;
        int cyc;
        int stalls;
        int held;
        bit st;

        build_reads(sa, sb, wr, ea, eb);
        idx = 0; cyc = 0; stalls = 0; held = 0;

        // Start cycle (controller idle)
        @(negedge clk);
        bus.start      = 1'b1;
        bus.cfg_skip_a = AW'(sa);
        bus.cfg_skip_b = AW'(sb);
        bus.cfg_wrap   = AW'(wr);
        bus.stall      = 1'($urandom_range(0, 1));
        #1;
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_done", int'(bus.done), 0);
        chk("idle_rd_en", int'(bus.rd_en), 0);

        // Load cycle: config inputs now garbage and must be ignored
        @(negedge clk);
        cyc++;
        bus.start      = 1'b0;
        bus.cfg_skip_a = AW'($urandom);
        bus.cfg_skip_b = AW'($urandom);
        bus.cfg_wrap   = AW'($urandom);
        bus.stall      = 1'($urandom_range(0, 1));
        #1;
        chk("load_busy", int'(bus.busy), 1);
        chk("load_rd_en", int'(bus.rd_en), 0);

        while (idx < NREADS && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (idx == st_idx && held < st_len) begin
                st = 1'b1;
                held++;
            end else begin
                st = ($urandom_range(0, 99) < stall_pct);
            end
            bus.stall = st;
            bus.start = start_in_run ? 1'($urandom_range(0, 1)) : 1'b0;
            if (idx == abort_idx) begin
                reset     = 1'b1;
                bus.stall = 1'b0;
                bus.start = 1'b0;
                @(negedge clk);
                #1;
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_rd_en", int'(bus.rd_en), 0);
                chk("rst_addr_a", int'(bus.addr_a), 0);
                chk("rst_addr_b", int'(bus.addr_b), 0);
                chk("rst_last", int'(bus.last), 0);
                chk("rst_done", int'(bus.done), 0);
                reset = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    chk("post_rst_done", int'(bus.done), 0);
                    chk("post_rst_busy", int'(bus.busy), 0);
                end
                return;
            end
            #1;
            chk("run_busy", int'(bus.busy), 1);
            chk("run_rd_en", int'(bus.rd_en), int'(!st));
            if (!st) begin
                chk("addr_a", int'(bus.addr_a), ea[idx]);
                chk("addr_b", int'(bus.addr_b), eb[idx]);
                chk("last", int'(bus.last), int'(idx == NREADS - 1));
                idx++;
            end else begin
                stalls++;
                chk("stall_last", int'(bus.last), 0);
            end
        end
        if (idx < NREADS) begin
            chk("run_timeout", idx, NREADS);
            return;
        end

        // Done cycle
        @(negedge clk);
        cyc++;
        bus.start = start_on_done;
        bus.stall = 1'($urandom_range(0, 1));
        #1;
        chk("done_pulse", int'(bus.done), 1);
        chk("done_busy", int'(bus.busy), 1);
        chk("done_rd_en", int'(bus.rd_en), 0);
        chk("done_latency", cyc, 3 + int'(LAST_B) + stalls);

        repeat (idle_gap) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.stall = 1'($urandom_range(0, 1));
            #1;
            chk("gap_busy", int'(bus.busy), 0);
            chk("gap_done", int'(bus.done), 0);
            chk("gap_rd_en", int'(bus.rd_en), 0);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.stall      = 1'b0;
        bus.cfg_skip_a = '0;
        bus.cfg_skip_b = '0;
        bus.cfg_wrap   = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_rd_en", int'(bus.rd_en), 0);
        chk("reset_addr_a", int'(bus.addr_a), 0);
        chk("reset_addr_b", int'(bus.addr_b), 0);
        chk("reset_last", int'(bus.last), 0);
        chk("reset_done", int'(bus.done), 0);
        reset = 1'b0;

        // Directed passes
        run_pass(2, 5, 15, 0, -1, 0, -1, 1'b0, 1'b0, 1);
        run_pass(2, 15, 1, 0, -1, 0, -1, 1'b0, 1'b0, 1);
        run_pass(2, 5, 15, 0, 4, 3, -1, 1'b0, 1'b0, 1);
        run_pass(2, 5, 15, 0, -1, 0, -1, 1'b1, 1'b1, 0);
        run_pass(3, 3, 15, 0, -1, 0, -1, 1'b0, 1'b0, 2);
        run_pass(2, 5, 15, 0, -1, 0, 5, 1'b0, 1'b0, 0);
        run_pass(2, 5, 15, 0, -1, 0, -1, 1'b0, 1'b0, 1);
        run_pass(12, 9, 3, 0, -1, 0, -1, 1'b0, 1'b0, 1);

        // Randomized passes
        for (int p = 0; p < 30; p++) begin
            run_pass(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), 30, -1, 0, -1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
